stream_width_packer: RTL and testbench

- Valid/ready width upsizer: packs RATIO consecutive narrow input beats into one wide output beat.
- Sits directly upstream of the pipeline break stage and feeds its i_valid/i_ready/i_data side, e.g. 32-bit producer into the 128-bit datapath.
- A beat marked i_last closes a packet early; the partial word carries a lane keep mask.
- Output is registered; the downstream break stage cuts the combinational ready path.

---
 rtl/stream_width_packer_if.sv | 34 +++
 rtl/stream_width_packer.sv | 103 ++++++++++
 tb/tb_stream_width_packer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/stream_width_packer_if.sv
// stream_width_packer_if
//   Groups the narrow input stream and the packed wide output stream of
//   stream_width_packer into one bundle.
//   Parameters: IN_WIDTH (narrow beat width), RATIO (beats per wide word).
//   Signals:
//     i_valid/i_ready/i_data/i_last   narrow input stream
//     o_valid/o_ready/o_data/o_keep/o_last   packed output stream
//   Modports:
//     master : environment side (drives the input stream, consumes the output)
//     slave  : packer side (consumes the input stream, drives the output)
interface stream_width_packer_if #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
);
  logic                      i_valid;
  logic                      i_ready;
  logic [IN_WIDTH-1:0]       i_data;
  logic                      i_last;
  logic                      o_valid;
  logic                      o_ready;
  logic [IN_WIDTH*RATIO-1:0] o_data;
  logic [RATIO-1:0]          o_keep;
  logic                      o_last;

  modport master (
    output i_valid, i_data, i_last, o_ready,
    input  i_ready, o_valid, o_data, o_keep, o_last
  );

  modport slave (
    input  i_valid, i_data, i_last, o_ready,
    output i_ready, o_valid, o_data, o_keep, o_last
  );
endinterface

// File: rtl/stream_width_packer.sv
// stream_width_packer
//   Valid/ready width upsizer: packs RATIO consecutive IN_WIDTH beats into one
//   IN_WIDTH*RATIO word, first beat in lane 0. A beat with i_last closes the
//   word early; o_keep marks the lanes holding real beats and unused upper
//   lanes are zero. The output word is registered.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    stream_width_packer_if.slave (input stream in, packed stream out)
module stream_width_packer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_width_packer_if.slave  bus
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int ASM_WIDTH = IN_WIDTH * (RATIO - 1);
  localparam int CNT_W     = $clog2(RATIO);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ASM_WIDTH-1:0] asm_q, asm_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [RATIO-1:0]     keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;

  logic                 accept;
  logic                 complete;
  logic [OUT_WIDTH-1:0] asm_ext;

  // Held output word stalls every input beat, partial or completing.
  assign bus.i_ready = ~valid_q | bus.o_ready;
  assign accept      = bus.i_valid & bus.i_ready;
  assign complete    = accept & ((cnt_q == CNT_W'(RATIO - 1)) | bus.i_last);

  // Pad the assembly register to full width so every lane index is in range.
  assign asm_ext = {{IN_WIDTH{1'b0}}, asm_q};

  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;

    if (valid_q && bus.o_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (complete) begin
        for (int k = 0; k < RATIO; k++) begin
          if (k < int'(cnt_q)) begin
            data_d[k*IN_WIDTH +: IN_WIDTH] = asm_ext[k*IN_WIDTH +: IN_WIDTH];
          end else if (k == int'(cnt_q)) begin
            data_d[k*IN_WIDTH +: IN_WIDTH] = bus.i_data;
          end else begin
            data_d[k*IN_WIDTH +: IN_WIDTH] = '0;
          end
          keep_d[k] = (k <= int'(cnt_q));
        end
        last_d  = bus.i_last;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (k == int'(cnt_q)) begin
            asm_d[k*IN_WIDTH +: IN_WIDTH] = bus.i_data;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Data path carries no reset; its content only matters while o_valid is set.
  always_ff @(posedge clk) begin
    asm_q  <= asm_d;
    data_q <= data_d;
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_keep  = keep_q;
  assign bus.o_last  = last_q;
endmodule

// File: tb/tb_stream_width_packer.sv
module tb_stream_width_packer;
  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } word_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   max_wait;
  word_t exp_q[$];

  stream_width_packer_if #(.IN_WIDTH(32), .RATIO(4)) bus ();

  stream_width_packer #(.IN_WIDTH(32), .RATIO(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.data = d;
    w.keep = k;
    w.last = l;
    exp_q.push_back(w);
  endtask

  // Monitor: every output handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.o_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got word %h with no expected word", bus.o_data);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        chk("sb_data", bus.o_data, w.data);
        chk("sb_keep", 128'(bus.o_keep), 128'(w.keep));
        chk("sb_last", 128'(bus.o_last), 128'(w.last));
      end
    end
  end

  // Offer one beat, wait (bounded) for acceptance, then check that o_valid
  // reflects whether this beat closed a word one cycle later.
  task automatic send_beat(input logic [31:0] d, input logic l, input logic completes);
    int waited;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_last  = l;
    waited = 0;
    @(negedge clk);
    while (!bus.i_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: beat %h not accepted, required within 50 cycles", d);
      bus.i_valid = 1'b0;
    end else begin
      if (waited > max_wait) max_wait = waited;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      chk("o_valid_after_beat", 128'(bus.o_valid), 128'(completes));
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    max_wait    = 0;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_last  = 1'b0;
    bus.o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", 128'(bus.o_valid), 128'(0));
    chk("rst_o_keep",  128'(bus.o_keep),  128'(0));
    chk("rst_o_last",  128'(bus.o_last),  128'(0));
    chk("rst_i_ready", 128'(bus.i_ready), 128'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two full words back to back, i_ready never drops.
    push_exp(128'h00000003_00000002_00000001_00000000, 4'b1111, 1'b0);
    push_exp(128'h00000007_00000006_00000005_00000004, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_beat(32'(i), (i == 7), (i == 3) || (i == 7));
    end
    chk("full_rate_no_stall", 128'(max_wait), 128'(0));

    // Short packet.
    push_exp(128'h00000000_0000000C_0000000B_0000000A, 4'b0111, 1'b1);
    send_beat(32'hA, 1'b0, 1'b0);
    send_beat(32'hB, 1'b0, 1'b0);
    send_beat(32'hC, 1'b1, 1'b1);

    // Single-beat packet.
    push_exp(128'h00000000_00000000_00000000_00000055, 4'b0001, 1'b1);
    send_beat(32'h55, 1'b1, 1'b1);

    // Backpressure: word held 5 cycles while a beat is offered and refused.
    push_exp(128'h00000023_00000022_00000021_00000020, 4'b1111, 1'b0);
    push_exp(128'h00000000_00000000_00000000_00000030, 4'b0001, 1'b1);
    send_beat(32'h20, 1'b0, 1'b0);
    send_beat(32'h21, 1'b0, 1'b0);
    send_beat(32'h22, 1'b0, 1'b0);
    send_beat(32'h23, 1'b0, 1'b1);
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h30;
    bus.i_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_o_valid", 128'(bus.o_valid), 128'(1));
      chk("bp_o_data",  bus.o_data, 128'h00000023_00000022_00000021_00000020);
      chk("bp_o_keep",  128'(bus.o_keep), 128'(4'b1111));
      chk("bp_i_ready", 128'(bus.i_ready), 128'(0));
      @(posedge clk);
      #1;
    end
    bus.o_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_i_ready", 128'(bus.i_ready), 128'(1));
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    chk("bp_reload_o_valid", 128'(bus.o_valid), 128'(1));
    chk("bp_reload_o_data",  bus.o_data, 128'h00000000_00000000_00000000_00000030);

    // Gapped input.
    push_exp(128'h00000043_00000042_00000041_00000040, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h40 + 32'(i), 1'b0, (i == 3));
      @(posedge clk);
      #1;
      if (i < 3) chk("gap_no_output", 128'(bus.o_valid), 128'(0));
    end

    // Reset mid-packet discards the partial lanes.
    send_beat(32'h50, 1'b0, 1'b0);
    send_beat(32'h51, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_o_valid", 128'(bus.o_valid), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_o_valid", 128'(bus.o_valid), 128'(0));
    push_exp(128'h00000013_00000012_00000011_00000010, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h10 + 32'(i), 1'b0, (i == 3));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
